// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the PC, issues in-order imem requests under a
// credit limit, buffers returned words with PC+4, and squashes wrong-path fetches on redirect.
//
// state  | meaning
// S_BOOT | first cycle after reset, no requests issued
// S_RUN  | normal fetch, held until reset
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
    logic [AW-1:0] af_wr_q, af_wr_d, af_rd_q, af_rd_d;
    logic [31:0]   out_instr_q, out_instr_d, out_pc4_q, out_pc4_d;

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc4   [DEPTH];
    logic [31:0]   af_addr [MAX_OUT];

    logic          issue, enq, deq, drop_rsp;
    logic [31:0]   enq_pc4;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_BOOT;
        else        state_q <= state_d;
    end

    // Credit: words already queued plus live (non-dropped) requests must fit the queue.
    always_comb begin
        state_d  = S_RUN;
        imem_req = 1'b0;
        if (rst_n && (state_q == S_RUN) && !redirect_valid &&
            (32'(outst_q) < MAX_OUT) &&
            ((32'(count_q) + 32'(outst_q) - 32'(drop_q)) < DEPTH)) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = rst_n && (count_q != '0);
    assign out_instr = out_instr_q;
    assign out_pc4   = out_pc4_q;

    assign issue    = imem_req && imem_ack;
    assign drop_rsp = imem_rvalid && (redirect_valid || (drop_q != '0));
    assign enq      = imem_rvalid && !drop_rsp;
    assign deq      = out_valid && out_ready;
    assign enq_pc4  = af_addr[af_rd_q] + 32'd4;

    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        af_wr_d     = af_wr_q;
        af_rd_d     = af_rd_q;
        out_instr_d = out_instr_q;
        out_pc4_d   = out_pc4_q;

        if (issue) begin
            pc_d    = pc_q + 32'd4;
            af_wr_d = (af_wr_q == AW'(MAX_OUT - 1)) ? '0 : af_wr_q + AW'(1);
        end
        if (imem_rvalid) begin
            af_rd_d = (af_rd_q == AW'(MAX_OUT - 1)) ? '0 : af_rd_q + AW'(1);
            if (drop_q != '0) drop_d = drop_q - OW'(1);
        end
        case ({issue, imem_rvalid})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        if (deq) head_d = head_q + PW'(1);
        if (enq) tail_d = tail_q + PW'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            drop_d  = outst_d;
        end

        // Output registers track the next head; the word being written now counts when it becomes the head.
        if (count_d != '0) begin
            if (enq && (head_d == tail_q)) begin
                out_instr_d = imem_rdata;
                out_pc4_d   = enq_pc4;
            end else begin
                out_instr_d = q_instr[head_d];
                out_pc4_d   = q_pc4[head_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            outst_q     <= '0;
            drop_q      <= '0;
            af_wr_q     <= '0;
            af_rd_q     <= '0;
            out_instr_q <= '0;
            out_pc4_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            af_wr_q     <= af_wr_d;
            af_rd_q     <= af_rd_d;
            out_instr_q <= out_instr_d;
            out_pc4_q   <= out_pc4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[tail_q] <= imem_rdata;
            q_pc4[tail_q]   <= enq_pc4;
        end
        if (issue) af_addr[af_wr_q] <= pc_q;
    end

    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outst_q != '0));
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        enq |-> (32'(count_q) < DEPTH));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory responder, queue-level reference model
// checked every cycle, plus directed literal checks for the key scenarios.
module tb_fetch_prefetch_queue;

    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    int tests = 0;
    int fails = 0;

    // reference model state
    ent_t        mq[$];
    logic [31:0] miss[$];
    int          m_out, m_drop;
    logic [31:0] m_pc;
    bit          m_boot, m_known;
    logic [31:0] last_i, last_p;

    // memory environment
    logic [31:0] pend_a[$];
    int          pend_due[$];
    int          cyc_n = 0;
    int          lat = 1;
    bit          rst_v = 1'b0;

    bit          seq_on = 1'b0;
    logic [31:0] seq_next;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hC0DE_1357;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic cyc(input bit ack, input bit ready, input bit redir,
                       input logic [31:0] rpc, input bit allow_rv);
        bit          rv, ereq, evld, iss;
        logic [31:0] ei, ep, a;
        @(negedge clk);
        rv = allow_rv && rst_v && (pend_a.size() > 0) && (pend_due[0] <= cyc_n);
        rst_n          = rst_v;
        imem_ack       = ack;
        out_ready      = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(pend_a[0]) : 32'h0BAD_BAD0;
        #1;
        ereq = 1'b0;
        evld = 1'b0;
        if (!rst_v) begin
            chk("rst_req", imem_req, 1'b0);
            chk("rst_valid", out_valid, 1'b0);
        end else if (m_known) begin
            ereq = m_boot && !redir && (m_out < MAX_OUT) &&
                   ((mq.size() + m_out - m_drop) < DEPTH);
            evld = (mq.size() > 0);
            ei   = evld ? mq[0].instr : last_i;
            ep   = evld ? mq[0].pc4   : last_p;
            chk("req", imem_req, ereq);
            chk("addr", imem_addr, m_pc);
            chk("valid", out_valid, evld);
            chk("instr", out_instr, ei);
            chk("pc4", out_pc4, ep);
            if (seq_on && out_valid && ready) begin
                chk("seq_pc4", out_pc4, seq_next);
                seq_next = seq_next + 32'd4;
            end
        end

        if (imem_req && ack) begin
            pend_a.push_back(imem_addr);
            pend_due.push_back(cyc_n + lat);
        end
        if (rv) begin
            void'(pend_a.pop_front());
            void'(pend_due.pop_front());
        end

        if (!rst_v) begin
            mq.delete();
            miss.delete();
            pend_a.delete();
            pend_due.delete();
            m_out   = 0;
            m_drop  = 0;
            m_pc    = 32'h0;
            m_boot  = 1'b0;
            last_i  = 32'h0;
            last_p  = 32'h0;
            m_known = 1'b1;
        end else if (m_known) begin
            iss = ereq && ack;
            if (evld) begin
                last_i = mq[0].instr;
                last_p = mq[0].pc4;
            end
            if (rv) a = miss.pop_front();
            m_out = m_out + int'(iss) - int'(rv);
            if (redir) begin
                mq.delete();
                m_drop = m_out;
                m_pc   = rpc;
            end else begin
                if (evld && ready) void'(mq.pop_front());
                if (rv) begin
                    if (m_drop > 0) m_drop--;
                    else mq.push_back('{mem_word(a), a + 32'd4});
                end
                if (iss) begin
                    miss.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_boot = 1'b1;
        end
        cyc_n++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
        m_known = 1'b0; last_i = 32'h0; last_p = 32'h0;

        // 1: reset then 1-cycle memory, always ready
        rst_v = 1'b0; lat = 1;
        repeat (3) cyc(1, 1, 0, 32'h0, 1);
        rst_v = 1'b1;
        seq_on = 1'b1; seq_next = 32'd4;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 1, 0, 32'h0, 1);
            if (i == 0) chk("t1_boot_noreq", imem_req, 1'b0);
            if (i == 2) chk("t1_no_valid_c2", out_valid, 1'b0);
            if (i == 3) begin
                chk("t1_valid_c3", out_valid, 1'b1);
                chk("t1_instr0", out_instr, mem_word(32'h0));
                chk("t1_pc4_0", out_pc4, 32'd4);
            end
            if (i == 4) chk("t1_pc4_1", out_pc4, 32'd8);
            if (i == 5) chk("t1_pc4_2", out_pc4, 32'd12);
        end

        // 2: stall consumer, queue fills, then drains in order
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 32'h0, 1);
        chk("t2_full_noreq", imem_req, 1'b0);
        chk("t2_full_valid", out_valid, 1'b1);
        chk("t2_model_cnt", 32'(mq.size()), 32'd4);
        chk("t2_model_out", 32'(m_out), 32'd0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 32'h0, 1);
        seq_on = 1'b0;

        // 3: latency 3, redirect with two requests outstanding
        lat = 3;
        for (int i = 0; i < 20; i++) begin
            if (m_out == 2) break;
            cyc(1, 1, 0, 32'h0, 1);
        end
        chk("t3_two_out", 32'(m_out), 32'd2);
        cyc(1, 1, 1, 32'h100, 0);
        chk("t3_drop2", 32'(m_drop), 32'd2);
        cyc(1, 1, 0, 32'h0, 1);
        chk("t3_flushed", out_valid, 1'b0);
        for (int i = 0; i < 30; i++) begin
            if (out_valid) break;
            cyc(1, 1, 0, 32'h0, 1);
        end
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_instr", out_instr, mem_word(32'h100));
        chk("t3_pc4", out_pc4, 32'h104);

        // 4: redirect coinciding with ack and a response
        lat = 1;
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 32'h0, 1);
        cyc(1, 1, 1, 32'h200, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 32'h0, 1);
            if (imem_req) break;
        end
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h200);
        for (int i = 0; i < 30; i++) begin
            cyc(1, 1, 0, 32'h0, 1);
            if (out_valid) break;
        end
        chk("t4_instr", out_instr, mem_word(32'h200));
        chk("t4_pc4", out_pc4, 32'h204);

        // 5: redirect to the last word of the address space
        cyc(1, 1, 1, 32'hFFFF_FFFC, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 32'h0, 1);
            if (imem_req) break;
        end
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 32'h0, 1);
        chk("t5_addr_wrap", imem_addr, 32'h0);
        for (int i = 0; i < 30; i++) begin
            if (out_valid) break;
            cyc(1, 1, 0, 32'h0, 1);
        end
        chk("t5_instr", out_instr, mem_word(32'hFFFF_FFFC));
        chk("t5_pc4", out_pc4, 32'h0);

        // 6: random traffic with one mid-run reset
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] rpc;
            rst_v = !(i == 5000 || i == 5001);
            lat   = $urandom_range(1, 4);
            rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                                : 32'($urandom_range(0, 1023)) << 2;
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0, rpc, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
